// File: rtl/i2c_phy_pkg.sv
// Shared opcodes, FSM state encoding and SCL quarter-phase constants for the I2C PHY engine.
package i2c_phy_pkg;

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // START/STOP always legal; data commands need 1..8 bits.
  function automatic logic cmd_legal(input logic [2:0] op, input logic [3:0] nbits);
    case (op)
      OP_START, OP_STOP: return 1'b1;
      OP_WRITE, OP_READ: return (nbits != 4'd0) && (nbits <= 4'd8);
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_phy_tick_gen.sv
// SCL quarter-period divider: one tick every CLK_DIV running cycles, frozen while the slave stretches.
module i2c_phy_tick_gen
  import i2c_phy_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       freeze,
  output logic       tick,
  output logic [1:0] q
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  assign tick = run && !freeze && (div == DIV_LAST);

  // Divider and quarter counter; both held at zero whenever the engine is not on the bus.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div <= '0;
      q   <= Q0;
    end else if (tick) begin
      div <= '0;
      q   <= q + 2'd1;
    end else if (!freeze) begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2c_phy_engine.sv
// Command-driven I2C / 3-wire master PHY: executes START/WRITE/READ/STOP on open-drain SCL/SDA.
module i2c_phy_engine
  import i2c_phy_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned BUS_MODE   = 0,
  parameter int unsigned STRETCH_EN = 1,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_nbits,
  input  logic       cmd_ack_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_ack,
  output logic       rsp_err,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [1:0]    q;
  logic          tick;
  logic          run;
  logic          freeze;
  logic          accept;
  logic          timeout_hit;
  logic [7:0]    data_r;
  logic [2:0]    bit_idx;
  logic          is_read;
  logic          ack_out_r;
  logic [TW-1:0] stretch_cnt;

  assign run         = state inside {ST_START, ST_BIT, ST_ACK, ST_STOP};
  assign cmd_ready   = (state == ST_IDLE) || (state == ST_DONE);
  assign busy        = ~cmd_ready;
  assign rsp_valid   = (state == ST_DONE);
  assign accept      = cmd_valid && cmd_ready;
  assign freeze      = (STRETCH_EN != 0) && run && q[1] && !scl_oe && !scl_i;
  assign timeout_hit = freeze && (stretch_cnt == TW'(TIMEOUT - 1));

  i2c_phy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .freeze (freeze),
    .tick   (tick),
    .q      (q)
  );

  // Stretch duration counter, restarted by every tick.
  always_ff @(posedge clk) begin
    if (reset || !run || tick) stretch_cnt <= '0;
    else if (freeze)           stretch_cnt <= stretch_cnt + TW'(1);
  end

  // Command FSM; pin levels change only at accept or on the tick that enters the next quarter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_data  <= '0;
      rsp_ack   <= 1'b0;
      rsp_err   <= 1'b0;
      data_r    <= '0;
      bit_idx   <= '0;
      is_read   <= 1'b0;
      ack_out_r <= 1'b0;
    end else if (timeout_hit) begin
      state   <= ST_DONE;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      rsp_err <= 1'b1;
    end else if (accept) begin
      rsp_data  <= '0;
      rsp_ack   <= 1'b0;
      rsp_err   <= 1'b0;
      data_r    <= cmd_data;
      bit_idx   <= 3'(cmd_nbits - 4'd1);
      is_read   <= (cmd_op == OP_READ);
      ack_out_r <= cmd_ack_out;
      if (!cmd_legal(cmd_op, cmd_nbits)) begin
        state   <= ST_DONE;
        rsp_err <= 1'b1;
      end else begin
        case (cmd_op)
          OP_START: begin
            state  <= ST_START;
            sda_oe <= 1'b0;
          end
          OP_STOP: begin
            state  <= ST_STOP;
            scl_oe <= 1'b1;
            sda_oe <= 1'b1;
          end
          default: begin
            state  <= ST_BIT;
            scl_oe <= 1'b1;
            sda_oe <= (cmd_op == OP_WRITE) && !cmd_data[3'(cmd_nbits - 4'd1)];
          end
        endcase
      end
    end else begin
      case (state)
        ST_DONE: state <= ST_IDLE;
        ST_START: if (tick) begin
          case (q)
            Q0:      scl_oe <= 1'b0;
            Q1:      sda_oe <= 1'b1;
            Q2:      scl_oe <= 1'b1;
            default: state  <= ST_DONE;
          endcase
        end
        ST_BIT: if (tick) begin
          case (q)
            Q1: scl_oe <= 1'b0;
            Q2: if (is_read) rsp_data <= {rsp_data[6:0], sda_i};
            Q3: begin
              // SCL is pulled low on leaving every slot so the next command starts from a low clock.
              scl_oe <= 1'b1;
              if (bit_idx != 3'd0) begin
                bit_idx <= bit_idx - 3'd1;
                sda_oe  <= !is_read && !data_r[bit_idx - 3'd1];
              end else if (BUS_MODE == 0) begin
                state  <= ST_ACK;
                sda_oe <= is_read && ack_out_r;
              end else begin
                state <= ST_DONE;
              end
            end
            default: ;
          endcase
        end
        ST_ACK: if (tick) begin
          case (q)
            Q1: scl_oe <= 1'b0;
            Q2: if (!is_read) rsp_ack <= ~sda_i;
            Q3: begin
              scl_oe <= 1'b1;
              state  <= ST_DONE;
            end
            default: ;
          endcase
        end
        ST_STOP: if (tick) begin
          case (q)
            Q0:      scl_oe <= 1'b0;
            Q1:      sda_oe <= 1'b0;
            Q3:      state  <= ST_DONE;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_phy_engine.sv
// Directed bench for i2c_phy_engine: vector table with bus monitor plus timeout and reset sequences.
module tb_i2c_phy_engine;
  import i2c_phy_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] cmd_nbits;
  logic       cmd_ack_out;
  logic       rsp_valid, rsp_ack, rsp_err, busy;
  logic [7:0] rsp_data;
  logic       scl_i, sda_i, scl_oe, sda_oe;
  logic       hold, slave_low;

  assign scl_i = ~scl_oe & ~hold;
  assign sda_i = ~sda_oe & ~slave_low;

  i2c_phy_engine #(.CLK_DIV(4), .BUS_MODE(0), .STRETCH_EN(1), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nbits(cmd_nbits), .cmd_ack_out(cmd_ack_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_err(rsp_err), .busy(busy), .scl_i(scl_i),
    .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  // Second engine with a short timeout and SCL permanently held low by the slave.
  logic       to_valid, to_ready, to_rsp_valid, to_rsp_ack, to_rsp_err, to_busy, to_scl_oe, to_sda_oe;
  logic [2:0] to_op;
  logic [7:0] to_rsp_data;
  logic       to_sda_i;
  assign to_sda_i = ~to_sda_oe;

  i2c_phy_engine #(.CLK_DIV(4), .BUS_MODE(0), .STRETCH_EN(1), .TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .cmd_valid(to_valid), .cmd_ready(to_ready), .cmd_op(to_op),
    .cmd_data(8'h00), .cmd_nbits(4'd8), .cmd_ack_out(1'b0), .rsp_valid(to_rsp_valid),
    .rsp_data(to_rsp_data), .rsp_ack(to_rsp_ack), .rsp_err(to_rsp_err), .busy(to_busy), .scl_i(1'b0),
    .sda_i(to_sda_i), .scl_oe(to_scl_oe), .sda_oe(to_sda_oe)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  data;
    logic [3:0]  nbits;
    logic        ack_out;
    logic [8:0]  slv;      // slave line level per slot (bit k = slot k), 1 = released
    int unsigned stretch;  // cycles the slave holds SCL low in the first slot's high phase
    int unsigned lat;
    logic [7:0]  edata;
    logic        eack;
    logic        eerr;
    logic        escl;     // pins at the rsp_valid cycle
    logic        esda;
    logic [8:0]  ecap;     // sda_oe seen at each SCL release, first release in the highest bit
    logic        esfall;   // SDA pulled low while SCL released (START condition)
    logic        esrise;   // SDA released while SCL released (STOP condition)
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] mk_slv(input logic [7:0] v, input int unsigned n, input logic a);
    logic [8:0] s;
    s = '1;
    for (int unsigned k = 0; k < n; k++) s[k] = v[n-1-k];
    s[n] = a;
    return s;
  endfunction

  // Issue one command at the current negedge, monitor the bus until rsp_valid, then compare.
  task automatic run_vec(input int idx, input vec_t v);
    int unsigned cnt = 0;
    int unsigned left = 0;
    int unsigned slot = 0;
    logic [8:0]  cap = '0;
    logic        sfall = 1'b0, srise = 1'b0, started = 1'b0, got = 1'b0;
    logic        pscl, psda;
    cmd_op      = v.op;
    cmd_data    = v.data;
    cmd_nbits   = v.nbits;
    cmd_ack_out = v.ack_out;
    cmd_valid   = 1'b1;
    hold        = (v.stretch != 0);
    pscl        = scl_oe;
    psda        = sda_oe;
    while (!got && cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        cmd_valid   = 1'b0;
        cmd_op      = 3'd7;
        cmd_data    = ~v.data;
        cmd_nbits   = 4'hF;
        cmd_ack_out = ~v.ack_out;
      end
      if (!psda && sda_oe && !pscl && !scl_oe) sfall = 1'b1;
      if (psda && !sda_oe && !pscl && !scl_oe) srise = 1'b1;
      if (pscl && !scl_oe) begin
        cap = {cap[7:0], sda_oe};
        if (slot < 9) slave_low = !v.slv[slot];
        slot++;
        if (hold && !started) begin
          started = 1'b1;
          left    = v.stretch;
        end
      end else if (started && hold) begin
        left--;
        if (left == 0) hold = 1'b0;
      end
      if (!pscl && scl_oe) slave_low = 1'b0;
      pscl = scl_oe;
      psda = sda_oe;
      got  = rsp_valid;
    end
    hold      = 1'b0;
    slave_low = 1'b0;
    chk($sformatf("v%0d rsp_valid seen", idx), 16'(got), 16'd1);
    chk($sformatf("v%0d latency", idx), 16'(cnt), 16'(v.lat));
    chk($sformatf("v%0d rsp_data", idx), 16'(rsp_data), 16'(v.edata));
    chk($sformatf("v%0d rsp_ack", idx), 16'(rsp_ack), 16'(v.eack));
    chk($sformatf("v%0d rsp_err", idx), 16'(rsp_err), 16'(v.eerr));
    chk($sformatf("v%0d scl_oe", idx), 16'(scl_oe), 16'(v.escl));
    chk($sformatf("v%0d sda_oe", idx), 16'(sda_oe), 16'(v.esda));
    chk($sformatf("v%0d sda per slot", idx), 16'(cap), 16'(v.ecap));
    chk($sformatf("v%0d start cond", idx), 16'(sfall), 16'(v.esfall));
    chk($sformatf("v%0d stop cond", idx), 16'(srise), 16'(v.esrise));
    chk($sformatf("v%0d cmd_ready", idx), 16'(cmd_ready), 16'd1);
  endtask

  initial begin
    vec_t        vt[13];
    int unsigned cnt;
    int unsigned seen;
    logic        got;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_nbits = '0; cmd_ack_out = 1'b0;
    hold = 1'b0; slave_low = 1'b0; to_valid = 1'b0; to_op = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset cmd_ready", 16'(cmd_ready), 16'd1);
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset rsp_valid", 16'(rsp_valid), 16'd0);
    chk("reset rsp_data", 16'(rsp_data), 16'd0);
    chk("reset rsp_ack", 16'(rsp_ack), 16'd0);
    chk("reset rsp_err", 16'(rsp_err), 16'd0);
    chk("reset scl_oe", 16'(scl_oe), 16'd0);
    chk("reset sda_oe", 16'(sda_oe), 16'd0);

    //        op        data   nb    ack   slave                     str lat   edata  ack   err   scl   sda   cap     sf    sr
    vt[0]  = '{OP_START, 8'h00, 4'd0, 1'b0, 9'h1FF,                   0, 17,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0};
    vt[1]  = '{OP_WRITE, 8'hA5, 4'd8, 1'b0, mk_slv(8'hFF, 8, 1'b0),  0, 145, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0B4, 1'b0, 1'b0};
    vt[2]  = '{OP_READ,  8'h00, 4'd8, 1'b0, mk_slv(8'h3C, 8, 1'b1),  0, 145, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[3]  = '{OP_READ,  8'h00, 4'd5, 1'b1, mk_slv(8'h16, 5, 1'b1),  0, 97,  8'h16, 1'b0, 1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0};
    vt[4]  = '{OP_WRITE, 8'hF3, 4'd4, 1'b0, 9'h1FF,                   0, 81,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h018, 1'b0, 1'b0};
    vt[5]  = '{3'd7,     8'h55, 4'd8, 1'b0, 9'h1FF,                   0, 1,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[6]  = '{OP_WRITE, 8'h55, 4'd0, 1'b0, 9'h1FF,                   0, 1,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[7]  = '{OP_READ,  8'h00, 4'd9, 1'b0, 9'h1FF,                   0, 1,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[8]  = '{OP_START, 8'h00, 4'd0, 1'b0, 9'h1FF,                   0, 17,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0};
    vt[9]  = '{OP_WRITE, 8'hFE, 4'd1, 1'b0, mk_slv(8'hFF, 1, 1'b0),  0, 33,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9'h002, 1'b0, 1'b0};
    vt[10] = '{OP_STOP,  8'h00, 4'd0, 1'b0, 9'h1FF,                   0, 17,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h001, 1'b0, 1'b1};
    vt[11] = '{3'd0,     8'h00, 4'd3, 1'b0, 9'h1FF,                   0, 1,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[12] = '{OP_WRITE, 8'hA5, 4'd8, 1'b0, mk_slv(8'hFF, 8, 1'b0), 50, 195, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0B4, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

    // Stretch that never ends: abort after 2 quarters + 16 frozen cycles.
    to_op    = OP_START;
    to_valid = 1'b1;
    cnt      = 0;
    got      = 1'b0;
    while (!got && cnt < 100) begin
      @(negedge clk);
      cnt++;
      to_valid = 1'b0;
      got      = to_rsp_valid;
    end
    chk("timeout rsp_valid seen", 16'(got), 16'd1);
    chk("timeout latency", 16'(cnt), 16'd25);
    chk("timeout rsp_err", 16'(to_rsp_err), 16'd1);
    chk("timeout scl_oe", 16'(to_scl_oe), 16'd0);
    chk("timeout sda_oe", 16'(to_sda_oe), 16'd0);
    chk("timeout cmd_ready", 16'(to_ready), 16'd1);
    chk("timeout busy", 16'(to_busy), 16'd0);
    chk("timeout rsp_data", 16'(to_rsp_data), 16'd0);
    chk("timeout rsp_ack", 16'(to_rsp_ack), 16'd0);

    // Reset in the middle of a WRITE (second bit slot, SCL and SDA both driven low).
    cmd_op = OP_WRITE; cmd_data = 8'hA5; cmd_nbits = 4'd8; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("pre-reset scl_oe", 16'(scl_oe), 16'd1);
    chk("pre-reset sda_oe", 16'(sda_oe), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset scl_oe", 16'(scl_oe), 16'd0);
    chk("mid reset sda_oe", 16'(sda_oe), 16'd0);
    chk("mid reset cmd_ready", 16'(cmd_ready), 16'd1);
    chk("mid reset rsp_valid", 16'(rsp_valid), 16'd0);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid reset stray rsp", 16'(seen), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
